// File: rtl/adc_boxcar_filter.sv
// Two-channel run-time configurable boxcar (moving-average) filter for the ADC path.
// Sliding-window or block-average output over 2^L samples, with output valid strobe and primed flag.
module adc_boxcar_filter #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_N_MAX       = 10
) (
  input  logic                        adc_clk,
  input  logic                        adc_rstn,
  input  logic [AXIS_TDATA_WIDTH-1:0] adc_dat_a,
  input  logic [AXIS_TDATA_WIDTH-1:0] adc_dat_b,
  input  logic                        in_valid,
  input  logic [3:0]                  cfg_log2_n,
  input  logic                        cfg_decim,
  input  logic                        clear,
  output logic [AXIS_TDATA_WIDTH-1:0] smooth_a,
  output logic [AXIS_TDATA_WIDTH-1:0] smooth_b,
  output logic                        out_valid,
  output logic                        primed
);

  localparam int ACC_W = ADC_WIDTH + LOG2_N_MAX;
  localparam int DEPTH = 1 << LOG2_N_MAX;
  localparam int CNT_W = LOG2_N_MAX + 1;

  function automatic logic [AXIS_TDATA_WIDTH-1:0] f_floor_avg(
    input logic signed [ACC_W-1:0] acc,
    input logic        [3:0]       l
  );
    logic signed [ACC_W-1:0] q;
    q = acc >>> l;
    return {{(AXIS_TDATA_WIDTH-ACC_W){q[ACC_W-1]}}, q};
  endfunction

  function automatic logic signed [ACC_W-1:0] f_sext(input logic signed [ADC_WIDTH-1:0] x);
    return {{LOG2_N_MAX{x[ADC_WIDTH-1]}}, x};
  endfunction

  logic signed [ADC_WIDTH-1:0]        r_buf_a [DEPTH];
  logic signed [ADC_WIDTH-1:0]        r_buf_b [DEPTH];
  logic signed [ACC_W-1:0]            r_acc_a, r_acc_b;
  logic        [LOG2_N_MAX-1:0]       r_wr_ptr;
  logic        [CNT_W-1:0]            r_fill, r_blk;
  logic        [3:0]                  r_l_prev;
  logic                               r_decim_prev;
  logic        [AXIS_TDATA_WIDTH-1:0] r_smooth_a, r_smooth_b;
  logic                               r_out_valid, r_primed;

  logic        [3:0]            w_l;
  logic        [CNT_W-1:0]      w_n;
  logic        [LOG2_N_MAX-1:0] w_rd_ptr;
  logic signed [ADC_WIDTH-1:0]  w_x_a, w_x_b;
  logic signed [ACC_W-1:0]      w_old_a, w_old_b;
  logic signed [ACC_W-1:0]      w_slide_a, w_slide_b, w_blk_a, w_blk_b;
  logic        [CNT_W-1:0]      w_fill_nxt;
  logic                         w_full, w_blk_last, w_flush, w_accept, w_wr_en;
  logic                         w_unused_hi;

  assign w_l        = (cfg_log2_n > 4'(LOG2_N_MAX)) ? 4'(LOG2_N_MAX) : cfg_log2_n;
  assign w_n        = CNT_W'(1) << w_l;
  assign w_x_a      = adc_dat_a[ADC_WIDTH-1:0];
  assign w_x_b      = adc_dat_b[ADC_WIDTH-1:0];
  assign w_unused_hi = ^{adc_dat_a[AXIS_TDATA_WIDTH-1:ADC_WIDTH], adc_dat_b[AXIS_TDATA_WIDTH-1:ADC_WIDTH]};

  // At the maximum window the read address wraps onto the write address; the
  // asynchronous read sees the sample before this edge overwrites it.
  assign w_rd_ptr   = r_wr_ptr - w_n[LOG2_N_MAX-1:0];
  assign w_full     = (r_fill == w_n);
  assign w_old_a    = w_full ? f_sext(r_buf_a[w_rd_ptr]) : '0;
  assign w_old_b    = w_full ? f_sext(r_buf_b[w_rd_ptr]) : '0;
  assign w_slide_a  = r_acc_a + f_sext(w_x_a) - w_old_a;
  assign w_slide_b  = r_acc_b + f_sext(w_x_b) - w_old_b;
  assign w_blk_a    = r_acc_a + f_sext(w_x_a);
  assign w_blk_b    = r_acc_b + f_sext(w_x_b);
  assign w_fill_nxt = w_full ? r_fill : r_fill + CNT_W'(1);
  assign w_blk_last = (r_blk == w_n - CNT_W'(1));

  assign w_flush  = clear | (w_l != r_l_prev) | (cfg_decim != r_decim_prev);
  assign w_accept = in_valid & ~w_flush;
  assign w_wr_en  = w_accept & ~cfg_decim;

  always_ff @(posedge adc_clk) begin
    if (w_wr_en) begin
      r_buf_a[r_wr_ptr] <= w_x_a;
      r_buf_b[r_wr_ptr] <= w_x_b;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_acc_a      <= '0;
      r_acc_b      <= '0;
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_blk        <= '0;
      r_l_prev     <= '0;
      r_decim_prev <= 1'b0;
      r_smooth_a   <= '0;
      r_smooth_b   <= '0;
      r_out_valid  <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_l_prev     <= w_l;
      r_decim_prev <= cfg_decim;
      r_out_valid  <= 1'b0;
      if (w_flush) begin
        r_acc_a  <= '0;
        r_acc_b  <= '0;
        r_fill   <= '0;
        r_blk    <= '0;
        r_primed <= 1'b0;
      end else if (w_accept) begin
        if (!cfg_decim) begin
          r_acc_a  <= w_slide_a;
          r_acc_b  <= w_slide_b;
          r_fill   <= w_fill_nxt;
          r_wr_ptr <= r_wr_ptr + LOG2_N_MAX'(1);
          if (w_fill_nxt == w_n) begin
            r_smooth_a  <= f_floor_avg(w_slide_a, w_l);
            r_smooth_b  <= f_floor_avg(w_slide_b, w_l);
            r_out_valid <= 1'b1;
            r_primed    <= 1'b1;
          end
        end else if (w_blk_last) begin
          // Block complete: emit and restart so consecutive blocks never overlap.
          r_smooth_a  <= f_floor_avg(w_blk_a, w_l);
          r_smooth_b  <= f_floor_avg(w_blk_b, w_l);
          r_out_valid <= 1'b1;
          r_primed    <= 1'b1;
          r_acc_a     <= '0;
          r_acc_b     <= '0;
          r_blk       <= '0;
        end else begin
          r_acc_a <= w_blk_a;
          r_acc_b <= w_blk_b;
          r_blk   <= r_blk + CNT_W'(1);
        end
      end
    end
  end

  assign smooth_a  = r_smooth_a;
  assign smooth_b  = r_smooth_b;
  assign out_valid = r_out_valid;
  assign primed    = r_primed;

endmodule

// File: tb/tb_adc_boxcar_filter.sv
// Scoreboard bench for adc_boxcar_filter: directed stimulus pushes expected averages,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_adc_boxcar_filter;

  logic        adc_clk = 1'b0;
  logic        adc_rstn;
  logic [31:0] adc_dat_a, adc_dat_b;
  logic        in_valid;
  logic [3:0]  cfg_log2_n;
  logic        cfg_decim, clear;
  logic [31:0] smooth_a, smooth_b;
  logic        out_valid, primed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t exp_q[$];

  adc_boxcar_filter #(
    .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .LOG2_N_MAX(10)
  ) dut (
    .adc_clk(adc_clk), .adc_rstn(adc_rstn),
    .adc_dat_a(adc_dat_a), .adc_dat_b(adc_dat_b),
    .in_valid(in_valid), .cfg_log2_n(cfg_log2_n), .cfg_decim(cfg_decim), .clear(clear),
    .smooth_a(smooth_a), .smooth_b(smooth_b), .out_valid(out_valid), .primed(primed)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  always @(negedge adc_clk) begin : monitor
    exp_t e;
    if (adc_rstn === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 at %0t expected no pending result", $time);
      end else begin
        e = exp_q.pop_front();
        chk("smooth_a", smooth_a, e.a);
        chk("smooth_b", smooth_b, e.b);
      end
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic push(input int a, input int b);
    exp_t e;
    e.a = 32'(a);
    e.b = 32'(b);
    exp_q.push_back(e);
  endtask

  // Upper data bits carry junk that the filter must ignore.
  task automatic smp(input int a, input int b);
    adc_dat_a = {18'h2AAAA, a[13:0]};
    adc_dat_b = {18'h15555, b[13:0]};
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc;
    adc_rstn   = 1'b0;
    adc_dat_a  = '0;
    adc_dat_b  = '0;
    in_valid   = 1'b0;
    cfg_log2_n = 4'd2;
    cfg_decim  = 1'b0;
    clear      = 1'b0;
    #23;
    chk("rst_smooth_a", smooth_a, 32'd0);
    chk("rst_smooth_b", smooth_b, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_primed", {31'd0, primed}, 32'd0);
    tick();
    adc_rstn = 1'b1;
    idle(2);

    // L=2 sliding, constant inputs
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) push(100, -100);
      smp(100, -100);
      if (i == 3) chk("l2_primed_early", {31'd0, primed}, 32'd0);
    end
    chk("l2_ov_latency", {31'd0, out_valid}, 32'd1);
    chk("l2_primed", {31'd0, primed}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      push(100, -100);
      smp(100, -100);
    end

    // L change 2->3 flushes; sample in the flush cycle is discarded
    cfg_log2_n = 4'd3;
    smp(5000, 5000);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_primed", {31'd0, primed}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(0, 0);
      smp(0, 0);
      if (i == 7) chk("l3_primed_early", {31'd0, primed}, 32'd0);
    end
    for (int k = 1; k <= 10; k++) begin
      push((k <= 8) ? 100 * k : 800, 0);
      smp(800, 0);
    end

    // L=1 floor rounding
    cfg_log2_n = 4'd1;
    idle(1);
    for (int i = 0; i < 6; i++) begin
      if (i >= 1) push(-8192, 8191);
      smp((i % 2 == 1) ? -8191 : -8192, 8191);
    end
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear_primed", {31'd0, primed}, 32'd0);
    chk("clear_hold_a", smooth_a, 32'hFFFF_E000);
    smp(8191, 8191);
    push(8191, 8191);
    smp(8191, 8191);
    push(8191, 8191);
    smp(8191, 8191);

    // N=1 passthrough
    cfg_log2_n = 4'd0;
    idle(1);
    push(7, -3);
    smp(7, -3);
    chk("n1_ov", {31'd0, out_valid}, 32'd1);
    idle(1);
    chk("n1_ov_gap", {31'd0, out_valid}, 32'd0);
    push(-8192, 8191);
    smp(-8192, 8191);

    // Maximum window (15 clamps to 10), full-scale inputs
    cfg_log2_n = 4'd15;
    idle(1);
    for (int i = 1; i <= 1024; i++) begin
      if (i == 1024) push(-8192, 8191);
      smp(-8192, 8191);
    end
    for (int k = 1; k <= 1024; k++) begin
      acc = 16383 * k - 8388608;
      push(acc >>> 10, 8191);
      smp(8191, 8191);
    end

    // Block-average mode with in_valid gaps
    cfg_decim  = 1'b1;
    cfg_log2_n = 4'd2;
    idle(1);
    chk("decim_primed_flush", {31'd0, primed}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) push(2, -3);
      if (i == 8) push(6, -7);
      smp(i, -i);
      if (i == 4) chk("decim_primed", {31'd0, primed}, 32'd1);
      if (i == 5) chk("decim_ov_mid", {31'd0, out_valid}, 32'd0);
      if (i % 3 == 0) idle(2);
    end

    // Asynchronous reset mid-stream, then cold start
    cfg_decim = 1'b0;
    idle(1);
    for (int i = 1; i <= 6; i++) begin
      if (i >= 4) push(40, -40);
      smp(40, -40);
    end
    idle(1);
    #2;
    adc_rstn = 1'b0;
    #1;
    chk("arst_smooth_a", smooth_a, 32'd0);
    chk("arst_smooth_b", smooth_b, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_primed", {31'd0, primed}, 32'd0);
    tick();
    tick();
    adc_rstn = 1'b1;
    idle(2);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) push(12, -12);
      smp(12, -12);
      if (i == 3) chk("cold_primed_early", {31'd0, primed}, 32'd0);
    end
    chk("cold_primed", {31'd0, primed}, 32'd1);
    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
